// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decade counter slice: digit type, limits and validity check.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the counter: holds a BCD digit, steps up/down by one, emits carry/borrow.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_nibble,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t q_digit,
    output logic       cout
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q_digit <= BCD_ZERO;
        end else if (load) begin
            q_digit <= bcd_valid(load_nibble) ? load_nibble : BCD_ZERO;
        end else if (step) begin
            if (up) begin
                q_digit <= (q_digit == BCD_MAX) ? BCD_ZERO : q_digit + 4'd1;
            end else begin
                q_digit <= (q_digit == BCD_ZERO) ? BCD_MAX : q_digit - 4'd1;
            end
        end
    end

    // Carry (up) or borrow (down) passes on only when this digit is stepping past its limit.
    always_comb begin
        cout = step & (up ? (q_digit == BCD_MAX) : (q_digit == BCD_ZERO));
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable up/down BCD counter built from a chain of decade cells, with load and terminal count.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  load_err
);

    logic [DIGITS:0] chain;
    logic            at_lim;
    logic            any_bad;

    always_comb begin
        at_lim  = 1'b1;
        any_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (up) begin
                at_lim = at_lim & (q[4*i +: 4] == BCD_MAX);
            end else begin
                at_lim = at_lim & (q[4*i +: 4] == BCD_ZERO);
            end
            any_bad = any_bad | ~bcd_valid(load_val[4*i +: 4]);
        end
    end

    // In saturating mode the chain is never started at the limit, so the final
    // carry cannot serve as tc there; it is rebuilt from the limit detect instead.
    always_comb begin
        chain[0] = en & ((WRAP != 0) | ~at_lim);
        tc       = (WRAP != 0) ? chain[DIGITS] : (en & at_lim);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk         (clk),
            .clr         (clr),
            .load        (load),
            .load_nibble (load_val[4*g +: 4]),
            .step        (chain[g]),
            .up          (up),
            .q_digit     (q[4*g +: 4]),
            .cout        (chain[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & any_bad;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: wrapping and saturating instances against an integer reference model.
module tb_bcd_down_counter;

    localparam int D    = 2;
    localparam int MAXV = 99;

    logic           clk = 1'b0;
    logic           clr = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [4*D-1:0] load_val = '0;
    logic [4*D-1:0] q1, q0;
    logic           tc1, tc0, lerr1, lerr0;

    int checks   = 0;
    int failures = 0;

    int  m1, m0;
    bit  mlerr;
    bit  mvalid = 1'b0;
    logic tcp1, tcp0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(D), .WRAP(1)) dut_wrap (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q1), .tc(tc1), .load_err(lerr1)
    );

    bcd_down_counter #(.DIGITS(D), .WRAP(0)) dut_sat (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q0), .tc(tc0), .load_err(lerr0)
    );

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int next_val(input int v, input bit u, input bit wrap);
        if (u) return (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
        return (v == 0) ? (wrap ? MAXV : 0) : v - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit c, input bit l, input bit e, input bit u, input logic [4*D-1:0] lv);
        int  lval;
        bit  bad;
        logic [3:0] nib;
        clr = c; load = l; en = e; up = u; load_val = lv;
        #1;
        tcp1 = tc1;
        tcp0 = tc0;
        if (mvalid) begin
            chk("tc_wrap", 32'(tc1), 32'(e && (u ? m1 == MAXV : m1 == 0)));
            chk("tc_sat",  32'(tc0), 32'(e && (u ? m0 == MAXV : m0 == 0)));
        end
        @(posedge clk);
        if (c) begin
            m1 = 0; m0 = 0; mlerr = 1'b0; mvalid = 1'b1;
        end else if (l) begin
            lval = 0; bad = 1'b0;
            for (int i = D - 1; i >= 0; i--) begin
                nib = lv[4*i +: 4];
                if (nib > 4'd9) begin
                    bad = 1'b1;
                    nib = 4'd0;
                end
                lval = lval * 10 + int'(nib);
            end
            m1 = lval; m0 = lval; mlerr = bad;
        end else begin
            mlerr = 1'b0;
            if (e) begin
                m1 = next_val(m1, u, 1'b1);
                m0 = next_val(m0, u, 1'b0);
            end
        end
        #1;
        if (mvalid) begin
            chk("q_wrap",    32'(q1),    32'(to_bcd(m1)));
            chk("q_sat",     32'(q0),    32'(to_bcd(m0)));
            chk("lerr_wrap", 32'(lerr1), 32'(mlerr));
            chk("lerr_sat",  32'(lerr0), 32'(mlerr));
        end
    endtask

    initial begin
        @(posedge clk);
        #2;
        // reset from unknown state
        step(1, 0, 0, 0, '0);
        chk("reset_q", 32'(q1), 32'h00);
        chk("reset_lerr", 32'(lerr1), 32'h0);
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, '0);
        chk("reset_tc_down", 32'(tcp1), 32'h1);
        chk("wrap_from_00", 32'(q1), 32'h99);
        chk("sat_from_00", 32'(q0), 32'h00);

        // countdown across digit boundary
        step(0, 1, 0, 0, 8'h21);
        step(0, 0, 1, 0, '0);
        chk("cd_20", 32'(q1), 32'h20);
        chk("cd_tc", 32'(tcp1), 32'h0);
        step(0, 0, 1, 0, '0);
        chk("cd_19", 32'(q1), 32'h19);
        step(0, 0, 1, 0, '0);
        chk("cd_18", 32'(q1), 32'h18);

        // underflow
        step(0, 1, 0, 0, 8'h01);
        step(0, 0, 1, 0, '0);
        chk("uf_00", 32'(q1), 32'h00);
        step(0, 0, 1, 0, '0);
        chk("uf_tc", 32'(tcp1), 32'h1);
        chk("uf_99", 32'(q1), 32'h99);
        chk("uf_sat_hold", 32'(q0), 32'h00);
        step(0, 0, 1, 0, '0);
        chk("uf_98", 32'(q1), 32'h98);
        chk("uf_sat_tc", 32'(tcp0), 32'h1);
        chk("uf_sat_hold2", 32'(q0), 32'h00);

        // overflow and direction flip
        step(0, 1, 0, 0, 8'h98);
        step(0, 0, 1, 1, '0);
        chk("ov_99", 32'(q1), 32'h99);
        step(0, 0, 1, 1, '0);
        chk("ov_00", 32'(q1), 32'h00);
        chk("ov_sat", 32'(q0), 32'h99);
        step(0, 0, 1, 0, '0);
        chk("flip_99", 32'(q1), 32'h99);
        chk("flip_sat", 32'(q0), 32'h98);

        // invalid load
        step(0, 1, 0, 0, 8'h3C);
        chk("bad_q", 32'(q1), 32'h30);
        chk("bad_lerr", 32'(lerr1), 32'h1);
        step(0, 0, 0, 0, '0);
        chk("bad_lerr_clear", 32'(lerr1), 32'h0);

        // priority
        step(0, 1, 1, 0, 8'h55);
        chk("load_over_en", 32'(q1), 32'h55);
        step(1, 1, 0, 0, 8'hFF);
        chk("clr_over_load_q", 32'(q1), 32'h00);
        chk("clr_over_load_lerr", 32'(lerr1), 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, '0);
        chk("hold_00", 32'(q1), 32'h00);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 75), 1'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
